// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, instruction/group types, FSM states and the
//            slot-mask helper for the fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INST_W  = 13;
    localparam int FETCH_W = 3;

    typedef logic [INST_W-1:0]  inst_t;
    typedef inst_t [FETCH_W-1:0] fetch_group_t;
    typedef logic [FETCH_W-1:0]  slot_mask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // A slot is valid only if it and every earlier slot hold a non-zero word.
    function automatic slot_mask_t slot_mask(input fetch_group_t grp);
        slot_mask_t m;
        logic       live;
        live = 1'b1;
        for (int k = 0; k < FETCH_W; k++) begin
            live = live & (grp[k] != '0);
            m[k] = live;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_out_reg
// Purpose  : Valid/ready output stage holding one fetch group, its PC and
//            slot mask; flush drops the held group.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_out_reg
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  fetch_group_t    load_inst,
    input  slot_mask_t      load_mask,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [PC_W-1:0] out_pc,
    output fetch_group_t    out_inst,
    output slot_mask_t      out_slot_valid
);

    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    fetch_group_t    r_inst;
    slot_mask_t      r_mask;

    // Payload only changes on load, so it stays stable while a group is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_mask  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_pc    <= load_pc;
            r_inst  <= load_inst;
            r_mask  <= load_mask;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_pc         = r_pc;
    assign out_inst       = r_inst;
    assign out_slot_valid = r_mask;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch PC owner and 3-wide instruction-memory sequencer with
//            start, stall, redirect and halt-on-zero. Optional performance
//            counters enabled by defining FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] mem_pc,
    input  fetch_group_t    mem_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output fetch_group_t    out_inst,
    output slot_mask_t      out_slot_valid,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_group_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    localparam logic [PC_W-1:0] c_pc_step = PC_W'(FETCH_W);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic            w_running;
    logic            w_can_take;
    logic            w_slot0_zero;
    logic            w_load;
    logic            w_halt;

    assign w_running    = (r_state == RUN);
    assign w_can_take   = ~out_valid | out_ready;
    assign w_slot0_zero = (mem_inst[0] == '0);
    assign w_load       = w_running & ~redirect_valid & w_can_take & ~w_slot0_zero;
    assign w_halt       = w_running & ~redirect_valid & w_can_take &  w_slot0_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            halted  <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over everything; IDLE only leaves on a coincident start.
            r_pc   <= redirect_pc;
            halted <= 1'b0;
            if (r_state != IDLE || start) begin
                r_state <= RUN;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_load) begin
                        r_pc <= r_pc + c_pc_step;
                    end else if (w_halt) begin
                        r_state <= HALT;
                        halted  <= 1'b1;
                    end
                end
                HALT: begin
                end
                default: begin
                    r_state <= IDLE;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_pc = r_pc;

    fetch_out_reg u_out_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (redirect_valid),
        .load           (w_load),
        .load_pc        (r_pc),
        .load_inst      (mem_inst),
        .load_mask      (slot_mask(mem_inst)),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_slot_valid (out_slot_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_group_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_group_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load && r_group_cnt != '1) begin
                r_group_cnt <= r_group_cnt + 32'd1;
            end
            if (w_running && out_valid && !out_ready && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_group_cnt = r_group_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] mem_pc;
    fetch_group_t    mem_inst;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    fetch_group_t    out_inst;
    slot_mask_t      out_slot_valid;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_group_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    inst_t mem [256];

    int vectors;
    int miscompares;

    // Model state: mode 0=idle 1=run 2=halt
    int           m_mode;
    int           m_pc;
    logic         m_valid;
    int           m_opc;
    fetch_group_t m_oinst;
    slot_mask_t   m_mask;
    longint       m_gcnt;
    longint       m_scnt;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mem_pc         (mem_pc),
        .mem_inst       (mem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_slot_valid (out_slot_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_group_cnt (perf_group_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            mem_inst[k] = mem[mem_pc + PC_W'(k)];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_valid = 1'b0; m_opc = 0;
        m_oinst = '0; m_mask = '0; m_gcnt = 0; m_scnt = 0;
    endtask

    task automatic model_step();
        logic busy_out;
        logic take;
        logic live;
        if (!rst_n) begin
            model_reset();
            return;
        end
        busy_out = m_valid && !out_ready;
        take     = !busy_out;
        if (m_mode == 1 && busy_out && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        if (redirect_valid) begin
            m_pc    = int'(redirect_pc);
            m_valid = 1'b0;
            if (m_mode != 0 || start) m_mode = 1;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1 && take) begin
            if (mem[m_pc] == 0) begin
                m_mode  = 2;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_opc   = m_pc;
                live    = 1'b1;
                for (int k = 0; k < FETCH_W; k++) begin
                    m_oinst[k] = mem[(m_pc + k) % 256];
                    live       = live && (m_oinst[k] != 0);
                    m_mask[k]  = live;
                end
                if (m_gcnt < 64'hFFFF_FFFF) m_gcnt++;
                m_pc = (m_pc + FETCH_W) % 256;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("mem_pc", 64'(mem_pc), 64'(m_pc));
        check("halted", 64'(halted), 64'(m_mode == 2));
        if (m_valid) begin
            check("out_pc", 64'(out_pc), 64'(m_opc));
            check("out_inst", 64'(out_inst), 64'(m_oinst));
            check("out_slot_valid", 64'(out_slot_valid), 64'(m_mask));
        end
`ifdef FETCH_PERF_CNT_EN
        check("perf_group_cnt", 64'(perf_group_cnt), 64'(m_gcnt));
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_scnt));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic       seen42;
        slot_mask_t mask42;
        vectors = 0; miscompares = 0;
        for (int i = 0; i < 256; i++) mem[i] = (i < 44) ? inst_t'(13'h100 + i) : '0;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        model_reset();
        repeat (2) cyc();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_mem_pc", 64'(mem_pc), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Start: first group visible two cycles after the pulse.
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_not_yet_valid", 64'(out_valid), 64'd0);
        cyc();
        check("first_out_valid", 64'(out_valid), 64'd1);
        check("first_out_pc", 64'(out_pc), 64'd0);
        repeat (3) cyc();
        check("pc9_out_pc", 64'(out_pc), 64'd9);

        // Backpressure for four cycles at out_pc=9.
        out_ready = 1'b0;
        repeat (4) cyc();
        check("stall_out_pc", 64'(out_pc), 64'd9);
        check("stall_inst0", 64'(out_inst[0]), 64'h109);
        check("stall_mem_pc", 64'(mem_pc), 64'd12);
        out_ready = 1'b1;
        cyc();
        check("resume_pc12", 64'(out_pc), 64'd12);
        cyc();
        check("resume_pc15", 64'(out_pc), 64'd15);

        // Run into the zero filler and halt.
        seen42 = 1'b0; mask42 = '0;
        for (int n = 0; n < 30 && !halted; n++) begin
            cyc();
            if (out_valid && out_pc == 8'd42) begin
                seen42 = 1'b1;
                mask42 = out_slot_valid;
            end
        end
        check("halt_reached", 64'(halted), 64'd1);
        check("last_group_seen", 64'(seen42), 64'd1);
        check("last_group_mask", 64'(mask42), 64'b011);
        check("halt_mem_pc", 64'(mem_pc), 64'd45);
        repeat (3) cyc();
        check("halt_frozen_pc", 64'(mem_pc), 64'd45);

        // Redirect out of HALT.
        redirect_valid = 1'b1; redirect_pc = 8'd20;
        cyc();
        redirect_valid = 1'b0;
        check("halt_redir_cleared", 64'(halted), 64'd0);
        cyc();
        check("halt_redir_pc", 64'(out_pc), 64'd20);

        // Redirect while a group is stalled at out_pc=6.
        redirect_valid = 1'b1; redirect_pc = 8'd0;
        cyc();
        redirect_valid = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b0;
        cyc();
        check("stall6_out_pc", 64'(out_pc), 64'd6);
        redirect_valid = 1'b1; redirect_pc = 8'd20;
        cyc();
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("redir_drop_valid", 64'(out_valid), 64'd0);
        cyc();
        check("redir_target_pc", 64'(out_pc), 64'd20);

        // Wrap-around with memory non-zero everywhere.
        for (int i = 44; i < 256; i++) mem[i] = inst_t'(13'h1000 + i);
        redirect_valid = 1'b1; redirect_pc = 8'd254;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("wrap_pc254", 64'(out_pc), 64'd254);
        check("wrap_slot0", 64'(out_inst[0]), 64'h10FE);
        check("wrap_slot2", 64'(out_inst[2]), 64'h0100);
        cyc();
        check("wrap_pc1", 64'(out_pc), 64'd1);
        cyc();
        check("wrap_pc4", 64'(out_pc), 64'd4);

        // Mixed ready pattern with an ignored start while running.
        for (int n = 0; n < 12; n++) begin
            out_ready = (n % 3) != 1;
            start = (n == 5);
            cyc();
        end
        start = 1'b0;

        // Asynchronous reset mid-stall.
        out_ready = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_mem_pc", 64'(mem_pc), 64'd0);
        check("async_halted", 64'(halted), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("async_group_cnt", 64'(perf_group_cnt), 64'd0);
        check("async_stall_cnt", 64'(perf_stall_cnt), 64'd0);
`endif
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();

        // Redirect in IDLE updates pc but stays idle; start+redirect runs.
        redirect_valid = 1'b1; redirect_pc = 8'd50;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("idle_redir_pc", 64'(mem_pc), 64'd50);
        check("idle_redir_no_valid", 64'(out_valid), 64'd0);
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd30;
        cyc();
        start = 1'b0; redirect_valid = 1'b0;
        cyc();
        check("start_redir_pc", 64'(out_pc), 64'd30);
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the 3-wide instruction memory read port. Owns the fetch PC and drives it to the combinational instruction memory. Registers each 3-instruction group into an output stage with a valid/ready handshake to decode. Handles start, backpressure stall, branch redirect, and halt at end-of-program (all-zero filler instruction).

Parameters:
PC_W, 8, fetch PC width; all PC arithmetic is mod 2^PC_W
INST_W, 13, instruction width
FETCH_W, 3, instructions per group; mem_inst slot k holds mem[mem_pc+k]
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle pulse; leave IDLE and begin fetching
mem_pc  out  PC_W  address to instruction memory; equals pc_q
mem_inst  in  FETCH_W x INST_W  combinational read data for mem_pc..mem_pc+2
out_valid  out  1  output group valid
out_ready  in  1  decode accepts group when out_valid & out_ready
out_pc  out  PC_W  PC of slot 0 of the output group
out_inst  out  FETCH_W x INST_W  output instruction group
out_slot_valid  out  FETCH_W  per-slot valid; contiguous ones from slot 0
redirect_valid  in  1  branch/flush request this cycle
redirect_pc  in  PC_W  redirect target
halted  out  1  high while in HALT

Behaviour:
- Reset, async on rst_n low: state=IDLE, pc_q=RESET_PC, out_valid=0, out_pc=0, out_inst=0, out_slot_valid=0, halted=0.
- States:
  - IDLE: no loads. start -> RUN.
  - RUN: normal fetch.
  - HALT: no loads; halted=1.
- load_en = (state==RUN) & ~redirect_valid & (~out_valid | out_ready) & (mem_inst[0]!=0).
- On load_en, next cycle:
  - out_inst=mem_inst; out_pc=pc_q; out_valid=1.
  - pc_q=pc_q+FETCH_W, mod 2^PC_W.
  - Latency: group at pc_q appears on outputs exactly 1 cycle after pc_q is driven.
- out_slot_valid[k]=1 iff mem_inst[j]!=0 for all j<=k. Example: insts {A,0,C} -> 3'b001.
- Stall (RUN & out_valid & ~out_ready): pc_q and all outputs hold.
- Consume with no new load: out_valid falls next cycle.
- Halt detect: RUN & slot-0 instruction ==0 & (~out_valid | out_ready) -> HALT next cycle. No load; pc_q holds. A pending valid group is consumed normally.
- Redirect has priority over load, halt and stall, and is legal in any state:
  - Next cycle: pc_q=redirect_pc, out_valid=0.
  - A handshake completing in the same cycle counts as consumed.
  - HALT or RUN -> RUN. IDLE stays IDLE, with pc updated.
- start outside IDLE: ignored. start together with redirect in IDLE: go to RUN with pc_q=redirect_pc.
- Wrap-around: pc_q=254 -> memory reads 254,255,0; next pc_q=1. Memory performs the +1/+2 mod 256; the controller drives only mem_pc.
- out_valid, once high, stays high with stable out_* until handshake or redirect.
- rst_n asserted mid-operation: immediate return to reset values; any in-flight group is discarded.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_group_cnt (32 bits) and perf_stall_cnt (32 bits), both reset to 0.
  - perf_group_cnt increments on each load_en.
  - perf_stall_cnt increments each cycle in RUN with out_valid & ~out_ready.
  - Both counters saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - localparams PC_W, INST_W, FETCH_W
  - typedef inst_t, logic [INST_W-1:0]
  - typedef fetch_group_t, inst_t [FETCH_W-1:0]
  - enum fetch_state_t {IDLE, RUN, HALT}
- fetch_ctrl imports fetch_pkg.
- Natural sub-module: fetch_out_reg, a valid/ready output register holding group, pc and slot mask, with a flush input. Control FSM and PC stay in fetch_ctrl.

Test Plan:
- Reset then start, memory 0..43 = nonzero insts, out_ready=1 -> out_pc sequence 0,3,6,... one group per cycle; first out_valid 2 cycles after start pulse.
- out_ready=0 for 4 cycles at out_pc=9 -> out_pc/out_inst held at 9; mem_pc held at 12; resumes 12,15 after ready returns.
- Program ends at 43 (mem[44..]=0), ready=1 -> last group out_pc=42, slot_valid=3'b011; then halted=1 and mem_pc=45 frozen.
- redirect_valid=1, redirect_pc=8'd20 while a group is stalled at out_pc=6 -> out_valid=0 next cycle, then out_pc=20. Repeat from HALT -> resumes RUN at 20.
- redirect_pc=8'd254, memory nonzero everywhere -> out_pc=254, then 1, then 4 (wrap).
- rst_n low mid-stall, asynchronous -> out_valid=0, mem_pc=0, state IDLE immediately; with FETCH_PERF_CNT_EN both counters read 0.
